conv_pool_engine: RTL and testbench
===================================

Name: conv_pool_engine

Overview:
- Parametrised successor of the fixed-kernel convolution block.
- Reads a 2^LOG_W x 2^LOG_H unsigned image.
- Applies a runtime-loadable signed 3x3 kernel with zero padding, then ReLU, arithmetic shift and saturation; writes the full feature map to L0.
- Writes a 2x2 max-pooled map to L1.
- Sits between gray-image memory and the downstream fully-connected stage.

Parameters:
- LOG_W, 7, log2 image width
- LOG_H, 7, log2 image height
- DATA_W, 8, unsigned pixel width
- OUT_W, 12, unsigned result width written to L0/L1
- SHIFT, 0, arithmetic right shift applied after ReLU

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- ready  in  1  start request
- busy  out  1  high from start accept until frame complete
- done  out  1  one-cycle pulse at frame end
- k_we  in  1  kernel register write strobe
- k_idx  in  4  coefficient index, 0..8 row-major (9 = bias)
- k_data  in  8  signed coefficient
- iaddr  out  LOG_W+LOG_H  image address, row-major y*2^LOG_W+x
- idata  in  DATA_W  image data, valid the cycle after iaddr
- wen_L0  out  1  L0 write enable
- addr_L0  out  LOG_W+LOG_H  L0 address
- w_data_L0  out  OUT_W  L0 data
- wen_L1  out  1  L1 write enable
- addr_L1  out  LOG_W+LOG_H-2  L1 address, row-major over (W/2)x(H/2)
- w_data_L1  out  OUT_W  L1 data

Behaviour:
- Interface decision: one clock `clk`; reset `reset` is asynchronous, active-high.
- Reset: all outputs 0, all coefficients 0, bias 0, state IDLE. Reset mid-frame aborts the frame; no further writes occur.
- Kernel load:
  - k_we in IDLE writes k_data to coef[k_idx] for idx 0..8.
  - Ignored while busy and for idx 10..15.
  - coef[dy*3+dx] multiplies pixel (y+dy-1, x+dx-1).
- FSM: IDLE -> FETCH -> CONV -> POOL -> (FETCH | DONE) -> IDLE.
- IDLE:
  - busy=0.
  - ready=1 sampled -> busy=1 next cycle; window origin (0,0).
  - k_we and ready in the same cycle: kernel write takes effect first.
- FETCH (17 cycles):
  - Cycle k<16 issues the address of patch pixel k of the 4x4 patch rows oy-1..oy+2, cols ox-1..ox+2.
  - Cycle k>=1 captures pixel k-1.
  - Out-of-image pixels: iaddr holds its previous value; the captured value is forced to 0 via a registered in-bounds flag.
- CONV (4 cycles):
  - Computes outputs (oy,ox), (oy,ox+1), (oy+1,ox), (oy+1,ox+1) in that order.
  - One output per cycle, each with wen_L0=1, matching addr_L0/w_data_L0.
  - Tracks the running maximum.
- POOL (1 cycle):
  - wen_L1=1.
  - addr_L1 = (oy/2)*(2^(LOG_W-1)) + ox/2.
  - w_data_L1 = maximum of the 4 results.
- Window advance:
  - ox += 2.
  - At ox wrap (last column pair): ox=0, oy += 2.
  - Last window (ox = W-2, oy = H-2) -> DONE.
- DONE (1 cycle): busy=0, done=1 -> IDLE.
- wen_L0/wen_L1 are 0 in every cycle not listed above.
- Frame length: 22*(W/2)*(H/2) cycles from first FETCH cycle to DONE.
- Arithmetic:
  - acc is signed, width DATA_W+13; sum of 9 products of zero-extended pixel and signed coefficient.
  - r = (acc<0) ? 0 : acc>>>SHIFT.
  - Output = (r > 2^OUT_W-1) ? 2^OUT_W-1 : r.
- Equal pool values: any is acceptable (values identical).

Optional Feature:
- Macro: CONV_BIAS_EN.
- Defined:
  - k_idx 9 writes a signed 8-bit bias, sign-extended to acc width.
  - Bias is added to acc before ReLU.
- Undefined:
  - k_idx 9 writes are ignored; no bias register exists.
  - Results are identical to the bias-0 case.

Test Plan:
- LOG_W=LOG_H=2, coef[4]=1 others 0, pixel=y*4+x, ready pulse ->
  - L0 equals the image.
  - L1 = {5,7,13,15} at addr 0..3.
  - done pulses 88 cycles after the first FETCH cycle.
- All coef=1, all pixels=1 -> L0 corners 4, edges 6, interior 9.
- All pixels 255, coef[4]=127, SHIFT=0, OUT_W=12 -> acc 32385 saturates; every L0/L1 write = 4095.
- coef[4]=-1, pixels nonzero -> every L0/L1 write = 0 (ReLU).
- CONV_BIAS_EN defined, coef all 0, bias=5 -> all writes 5.
- CONV_BIAS_EN undefined, same stimulus -> all writes 0.
- Reset asserted during the 2nd window's CONV ->
  - Outputs 0 the same cycle; no further wen pulses; coefficients cleared.
  - A subsequent reload plus ready completes a full frame correctly.

Source files
------------

// File: rtl/conv_pool_engine.sv
// conv_pool_engine: 3x3 convolution (zero padded) + ReLU + shift + saturation
// over a 2^LOG_W x 2^LOG_H image, writing the full feature map to L0 and a
// 2x2 max-pooled map to L1. The engine processes one 2x2 output window at a
// time. For each window it fetches a 4x4 input patch, produces four results,
// and then writes one pooled value.
// Optional feature: define CONV_BIAS_EN to add a signed 8-bit bias (k_idx 9).
module conv_pool_engine #(
    parameter int LOG_W  = 7,
    parameter int LOG_H  = 7,
    parameter int DATA_W = 8,
    parameter int OUT_W  = 12,
    parameter int SHIFT  = 0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     ready,
    output logic                     busy,
    output logic                     done,
    input  logic                     k_we,
    input  logic [3:0]               k_idx,
    input  logic [7:0]               k_data,
    output logic [LOG_W+LOG_H-1:0]   iaddr,
    input  logic [DATA_W-1:0]        idata,
    output logic                     wen_L0,
    output logic [LOG_W+LOG_H-1:0]   addr_L0,
    output logic [OUT_W-1:0]         w_data_L0,
    output logic                     wen_L1,
    output logic [LOG_W+LOG_H-3:0]   addr_L1,
    output logic [OUT_W-1:0]         w_data_L1
);

    localparam int AW    = LOG_W + LOG_H;
    localparam int ACC_W = DATA_W + 13;
    // Saturation limit; OUT_W is assumed narrower than the accumulator.
    localparam logic [ACC_W-1:0] SAT_MAX = ACC_W'((64'd1 << OUT_W) - 64'd1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_CONV,
        S_POOL,
        S_DONE
    } state_t;

    state_t state, state_nx;

    logic [4:0]        fcnt;       // fetch cycle 0..16
    logic [1:0]        ccnt;       // conv output 0..3
    logic [LOG_W-1:0]  ox;         // window origin column (even)
    logic [LOG_H-1:0]  oy;         // window origin row (even)
    logic              inb_q;      // in-bounds flag of the address issued last cycle
    logic [AW-1:0]     iaddr_q;    // last in-bounds address, held for padding cycles
    logic [OUT_W-1:0]  max_q;      // running maximum over the window's four results

    logic signed [7:0] coef [9];
`ifdef CONV_BIAS_EN
    logic signed [7:0] bias;
`endif
    logic [DATA_W-1:0] patch [16];

    logic [LOG_H+1:0]  prow;
    logic [LOG_W+1:0]  pcol;
    logic              inb;
    logic [AW-1:0]     paddr;

    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] pix_s;
    logic signed [ACC_W-1:0] coef_s;
    logic [3:0]              pidx;
    logic [ACC_W-1:0]        relu;
    logic [OUT_W-1:0]        res;
    logic                    last_win;

    // Patch pixel address for the current fetch cycle and its in-bounds test.
    // Rows/cols are computed two bits wider than the image so that both -1 and
    // the one-past-the-end index show up as a nonzero top field.
    always_comb begin
        prow  = {2'b00, oy} + {{LOG_H{1'b0}}, fcnt[3:2]} - (LOG_H+2)'(1);
        pcol  = {2'b00, ox} + {{LOG_W{1'b0}}, fcnt[1:0]} - (LOG_W+2)'(1);
        inb   = (state == S_FETCH) && !fcnt[4]
                && (prow[LOG_H+1:LOG_H] == 2'b00)
                && (pcol[LOG_W+1:LOG_W] == 2'b00);
        paddr = {prow[LOG_H-1:0], pcol[LOG_W-1:0]};
    end

    // Out-of-image fetches leave the address bus unchanged.
    assign iaddr = inb ? paddr : iaddr_q;

    // 3x3 multiply-accumulate over the patch sub-window for conv output ccnt,
    // then ReLU, shift, and saturation.
    always_comb begin
        // NOTE: every variable gets a value before any branch, so no latch is inferred.
        acc    = '0;
        pix_s  = '0;
        coef_s = '0;
        pidx   = '0;
`ifdef CONV_BIAS_EN
        acc = {{(ACC_W-8){bias[7]}}, bias};
`endif
        for (int dy = 0; dy < 3; dy++) begin
            for (int dx = 0; dx < 3; dx++) begin
                pidx   = 4'((int'(ccnt[1]) + dy) * 4 + int'(ccnt[0]) + dx);
                pix_s  = $signed({{(ACC_W-DATA_W){1'b0}}, patch[pidx]});
                coef_s = {{(ACC_W-8){coef[4'(dy*3 + dx)][7]}}, coef[4'(dy*3 + dx)]};
                acc    = acc + pix_s * coef_s;
            end
        end
        relu = acc[ACC_W-1] ? '0 : ACC_W'(acc >>> SHIFT);
        res  = (relu > SAT_MAX) ? '1 : relu[OUT_W-1:0];
    end

    assign last_win = (&ox[LOG_W-1:1]) && (&oy[LOG_H-1:1]);

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) state <= S_IDLE;
        else       state <= state_nx;
    end

    // Next-state logic and all outputs; everything idles at zero.
    always_comb begin
        state_nx  = state;
        busy      = 1'b0;
        done      = 1'b0;
        wen_L0    = 1'b0;
        addr_L0   = '0;
        w_data_L0 = '0;
        wen_L1    = 1'b0;
        addr_L1   = '0;
        w_data_L1 = '0;
        case (state)
            S_IDLE: begin
                if (ready) state_nx = S_FETCH;
            end
            S_FETCH: begin
                busy = 1'b1;
                if (fcnt == 5'd16) state_nx = S_CONV;
            end
            S_CONV: begin
                busy      = 1'b1;
                wen_L0    = 1'b1;
                // Origins are even, so adding the 0/1 offset is a concatenation.
                addr_L0   = {oy[LOG_H-1:1], ccnt[1], ox[LOG_W-1:1], ccnt[0]};
                w_data_L0 = res;
                if (ccnt == 2'd3) state_nx = S_POOL;
            end
            S_POOL: begin
                busy      = 1'b1;
                wen_L1    = 1'b1;
                addr_L1   = {oy[LOG_H-1:1], ox[LOG_W-1:1]};
                w_data_L1 = max_q;
                state_nx  = last_win ? S_DONE : S_FETCH;
            end
            S_DONE: begin
                done     = 1'b1;
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Window sequencing, fetch bookkeeping, and the running maximum.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fcnt    <= '0;
            ccnt    <= '0;
            ox      <= '0;
            oy      <= '0;
            inb_q   <= 1'b0;
            iaddr_q <= '0;
            max_q   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (ready) begin
                        fcnt <= '0;
                        ccnt <= '0;
                        ox   <= '0;
                        oy   <= '0;
                    end
                end
                S_FETCH: begin
                    inb_q <= inb;
                    if (inb) iaddr_q <= paddr;
                    if (fcnt == 5'd16) begin
                        fcnt <= '0;
                        ccnt <= '0;
                    end else begin
                        fcnt <= fcnt + 5'd1;
                    end
                end
                S_CONV: begin
                    ccnt <= ccnt + 2'd1;
                    if (ccnt == 2'd0 || res > max_q) max_q <= res;
                end
                S_POOL: begin
                    ox <= ox + LOG_W'(2);
                    if (&ox[LOG_W-1:1]) oy <= oy + LOG_H'(2);
                end
                default: ;
            endcase
        end
    end

    // Patch capture: pixel k-1 arrives while pixel k is being addressed.
    // NOTE: the patch is pure datapath storage, always overwritten before use, so it carries no reset.
    always_ff @(posedge clk) begin
        if (state == S_FETCH && fcnt != 5'd0)
            patch[4'(fcnt - 5'd1)] <= inb_q ? idata : '0;
    end

    // Kernel (and optional bias) registers; writable only while idle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 9; i++) coef[i] <= '0;
`ifdef CONV_BIAS_EN
            bias <= '0;
`endif
        end else if (state == S_IDLE && k_we) begin
            if (k_idx < 4'd9) coef[k_idx] <= k_data;
`ifdef CONV_BIAS_EN
            else if (k_idx == 4'd9) bias <= k_data;
`endif
        end
    end

endmodule

// File: tb/tb_conv_pool_engine.sv
// Directed bench for conv_pool_engine on a 4x4 image (LOG_W = LOG_H = 2).
module tb_conv_pool_engine;

    localparam int LOG_W  = 2;
    localparam int LOG_H  = 2;
    localparam int DATA_W = 8;
    localparam int OUT_W  = 12;
    localparam int SHIFT  = 0;
    localparam int AW     = LOG_W + LOG_H;

    logic              clk;
    logic              reset;
    logic              ready;
    logic              busy;
    logic              done;
    logic              k_we;
    logic [3:0]        k_idx;
    logic [7:0]        k_data;
    logic [AW-1:0]     iaddr;
    logic [DATA_W-1:0] idata;
    logic              wen_L0;
    logic [AW-1:0]     addr_L0;
    logic [OUT_W-1:0]  w_data_L0;
    logic              wen_L1;
    logic [AW-3:0]     addr_L1;
    logic [OUT_W-1:0]  w_data_L1;

    conv_pool_engine #(
        .LOG_W (LOG_W),
        .LOG_H (LOG_H),
        .DATA_W(DATA_W),
        .OUT_W (OUT_W),
        .SHIFT (SHIFT)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .ready    (ready),
        .busy     (busy),
        .done     (done),
        .k_we     (k_we),
        .k_idx    (k_idx),
        .k_data   (k_data),
        .iaddr    (iaddr),
        .idata    (idata),
        .wen_L0   (wen_L0),
        .addr_L0  (addr_L0),
        .w_data_L0(w_data_L0),
        .wen_L1   (wen_L1),
        .addr_L1  (addr_L1),
        .w_data_L1(w_data_L1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    // Image memory with one-cycle read latency.
    logic [7:0] img [16];
    always @(posedge clk) idata <= img[iaddr];

    // L0/L1 capture memories, sampled on the falling edge.
    logic [OUT_W-1:0] l0 [16];
    logic [OUT_W-1:0] l1 [4];
    int n_l0 = 0;
    int n_l1 = 0;
    logic clr;
    always @(negedge clk) begin
        if (clr) begin
            for (int i = 0; i < 16; i++) l0[i] = 'x;
            for (int i = 0; i < 4; i++)  l1[i] = 'x;
            n_l0 = 0;
            n_l1 = 0;
        end else begin
            if (wen_L0) begin l0[addr_L0] = w_data_L0; n_l0++; end
            if (wen_L1) begin l1[addr_L1] = w_data_L1; n_l1++; end
        end
    end

    int checks = 0;
    int errors = 0;
    int kern [9];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int idx, input int val);
        k_we   = 1'b1;
        k_idx  = 4'(idx);
        k_data = 8'(val);
        tick();
        k_we   = 1'b0;
    endtask

    task automatic load_all();
        for (int i = 0; i < 9; i++) load(i, kern[i]);
    endtask

    // Run one frame. poke: try a kernel write while busy.
    // kstart: write coef[4]=1 in the same cycle as ready.
    task automatic run_frame(input bit poke, input bit kstart);
        int t0, t1;
        bit got;
        clr = 1'b1;
        tick();
        clr = 1'b0;
        ready = 1'b1;
        if (kstart) begin k_we = 1'b1; k_idx = 4'd4; k_data = 8'd1; end
        tick();
        ready = 1'b0;
        k_we  = 1'b0;
        @(negedge clk);
        check("busy_after_ready", busy, 1);
        t0 = cyc;
        if (poke) begin
            tick();
            k_we = 1'b1; k_idx = 4'd4; k_data = 8'd0;
            tick();
            k_we = 1'b0;
        end
        got = 1'b0;
        t1  = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (done) begin got = 1'b1; t1 = cyc; break; end
        end
        check("done_seen", 32'(got), 1);
        check("frame_len", t1 - t0, 88);
        check("busy_at_done", busy, 0);
        check("l0_write_count", n_l0, 16);
        check("l1_write_count", n_l1, 4);
        @(negedge clk);
        check("done_one_cycle", done, 0);
        tick();
    endtask

    function automatic int ones_val(input int y, input int x);
        int ry, rx;
        ry = (y == 0 || y == 3) ? 2 : 3;
        rx = (x == 0 || x == 3) ? 2 : 3;
        return ry * rx;
    endfunction

    initial begin
        int w, bad, bias_exp;
        int exp_l1 [4];
        reset = 1'b1;
        ready = 1'b0;
        k_we  = 1'b0;
        k_idx = '0;
        k_data = '0;
        clr   = 1'b0;
        for (int i = 0; i < 16; i++) img[i] = 8'(i);

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        check("rst_ctrl", {busy, done, wen_L0, wen_L1}, 0);
        check("rst_iaddr", iaddr, 0);
        check("rst_L0", {addr_L0, w_data_L0}, 0);
        check("rst_L1", {addr_L1, w_data_L1}, 0);
        reset = 1'b0;
        tick();

        // Identity kernel: L0 reproduces the image. A kernel write while busy is ignored.
        kern = '{0, 0, 0, 0, 1, 0, 0, 0, 0};
        load_all();
        run_frame(1'b1, 1'b0);
        for (int i = 0; i < 16; i++) check($sformatf("id_l0[%0d]", i), l0[i], i);
        exp_l1 = '{5, 7, 13, 15};
        for (int i = 0; i < 4; i++) check($sformatf("id_l1[%0d]", i), l1[i], exp_l1[i]);

        // All ones: corners 4, edges 6, interior 9; every pooled quadrant 9.
        for (int i = 0; i < 16; i++) img[i] = 8'd1;
        kern = '{1, 1, 1, 1, 1, 1, 1, 1, 1};
        load_all();
        run_frame(1'b0, 1'b0);
        for (int y = 0; y < 4; y++)
            for (int x = 0; x < 4; x++)
                check($sformatf("ones_l0[%0d,%0d]", y, x), l0[y*4+x], ones_val(y, x));
        for (int i = 0; i < 4; i++) check($sformatf("ones_l1[%0d]", i), l1[i], 9);

        // 255 * 127 = 32385 saturates to 4095.
        for (int i = 0; i < 16; i++) img[i] = 8'd255;
        kern = '{0, 0, 0, 0, 127, 0, 0, 0, 0};
        load_all();
        run_frame(1'b0, 1'b0);
        for (int i = 0; i < 16; i++) check($sformatf("sat_l0[%0d]", i), l0[i], 4095);
        for (int i = 0; i < 4; i++)  check($sformatf("sat_l1[%0d]", i), l1[i], 4095);

        // Negative centre tap on positive pixels: ReLU clamps to 0.
        for (int i = 0; i < 16; i++) img[i] = 8'(i + 1);
        kern = '{0, 0, 0, 0, -1, 0, 0, 0, 0};
        load_all();
        run_frame(1'b0, 1'b0);
        for (int i = 0; i < 16; i++) check($sformatf("relu_l0[%0d]", i), l0[i], 0);
        for (int i = 0; i < 4; i++)  check($sformatf("relu_l1[%0d]", i), l1[i], 0);

        // Zero kernel with bias 5; index 12 is not a register.
`ifdef CONV_BIAS_EN
        bias_exp = 5;
`else
        bias_exp = 0;
`endif
        kern = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
        load_all();
        load(9, 5);
        load(12, 100);
        run_frame(1'b0, 1'b0);
        for (int i = 0; i < 16; i++) check($sformatf("bias_l0[%0d]", i), l0[i], bias_exp);
        for (int i = 0; i < 4; i++)  check($sformatf("bias_l1[%0d]", i), l1[i], bias_exp);

        // Reset during the second window's CONV.
        for (int i = 0; i < 16; i++) img[i] = 8'(i);
        kern = '{0, 0, 0, 0, 1, 0, 0, 0, 0};
        load_all();
        ready = 1'b1;
        tick();
        ready = 1'b0;
        w = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (wen_L0) w++;
            if (w == 5) break;
        end
        check("reached_win2_conv", w, 5);
        reset = 1'b1;
        #1;
        check("midrst_ctrl", {busy, done, wen_L0, wen_L1}, 0);
        check("midrst_L0", {addr_L0, w_data_L0}, 0);
        check("midrst_L1", {addr_L1, w_data_L1}, 0);
        check("midrst_iaddr", iaddr, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (wen_L0 || wen_L1 || busy) bad++;
        end
        check("quiet_after_reset", bad, 0);
        tick();

        // Coefficients cleared by reset: a frame without reload writes zeros.
        run_frame(1'b0, 1'b0);
        for (int i = 0; i < 16; i++) check($sformatf("clr_l0[%0d]", i), l0[i], 0);

        // Reload. The centre tap is written in the same cycle as ready.
        kern = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
        load_all();
        run_frame(1'b0, 1'b1);
        for (int i = 0; i < 16; i++) check($sformatf("rec_l0[%0d]", i), l0[i], i);
        for (int i = 0; i < 4; i++)  check($sformatf("rec_l1[%0d]", i), l1[i], exp_l1[i]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
